// File: rtl/vram_pkg.sv
// vram_pkg
// Shared definitions for the VRAM arbiter slice: the scan FSM state
// encoding, the default display geometry and the visible frame size.
// No ports; imported with "import vram_pkg::*;".
package vram_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_HBLANK = 2'd1,
    ST_VBLANK = 2'd2
  } scan_state_t;

  // Visible pixel count for an arbitrary geometry, so parameterised
  // instances do not depend on the default FRAME_PIXELS.
  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// wr_fifo
// Circular write buffer between the game-logic writer and the VRAM port.
// Ports:
//   pixelClock  clock, rising edge
//   resetN      synchronous active-low reset (empties the buffer)
//   push        write push_data at the tail (ignored when full)
//   push_data   entry to store
//   pop         drop the head entry (ignored when empty)
//   head_data   entry at the head, valid when empty=0
//   count       number of stored entries (0..DEPTH)
//   full/empty  status decoded from count
import vram_pkg::*;

module wr_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic                     pixelClock,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Status and qualified handshakes; DEPTH is a power of two so the
  // pointers wrap on their own.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    push_ok   = push & ~full;
    pop_ok    = pop & ~empty;
    head_data = storage[rd_ptr];
  end

  // Entry storage needs no reset: an entry is only read after it is written.
  always_ff @(posedge pixelClock) begin
    if (push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a push and pop together leave
  // the count unchanged while both pointers advance.
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port VRAM between display scan-out and a buffered
// game-logic writer. The display owns the port whenever draw is high;
// buffered writes drain one per cycle while draw is low.
// Optional feature macro: VRAM_STATS_EN adds stall_count.
// Ports:
//   pixelClock, resetN          clock and synchronous active-low reset
//   draw, v_sync_signal         timing from msync
//   wr_valid/wr_addr/wr_data    writer request; wr_ready accepts it
//   mem_addr/mem_we/mem_wdata   VRAM command, mem_rdata 1-cycle read data
//   pixel_data/pixel_valid      scan-out pixel to the DAC
//   frame_done                  pulse after the last visible pixel fetch
//   stall_count                 (VRAM_STATS_EN) saturating blocked-cycle count
import vram_pkg::*;

module vram_arbiter #(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              pixelClock,
  input  logic              resetN,
  input  logic              draw,
  input  logic              v_sync_signal,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid,
  output logic              frame_done
`ifdef VRAM_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int                PIXELS    = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam int                FW        = ADDR_W + DATA_W;
  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;

  scan_state_t       state;
  scan_state_t       next_state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              vsync_q;
  logic              vsync_rise;
  logic              pv_q;
  logic              fd_q;

  logic              push;
  logic              pop;
  logic [FW-1:0]     head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign vsync_rise = v_sync_signal & ~vsync_q;

  wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pixelClock (pixelClock),
    .resetN     (resetN),
    .push       (push),
    .push_data  ({wr_addr, wr_data}),
    .pop        (pop),
    .head_data  (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // State register.
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      state <= ST_VBLANK;
    end else begin
      state <= next_state;
    end
  end

  // Leaving a scan run goes to vertical blanking only when the run ended
  // on the last visible pixel; fd_q marks exactly that previous fetch.
  always_comb begin
    next_state = state;
    if (draw) begin
      next_state = ST_SCAN;
    end else if (state == ST_SCAN) begin
      next_state = fd_q ? ST_VBLANK : ST_HBLANK;
    end
  end

  // Port ownership follows the live draw input so the display never
  // waits; everything is forced quiet while reset is asserted so a reset
  // mid-drain issues no further write.
  always_comb begin
    wr_ready    = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = hold_addr;
    mem_wdata   = hold_wdata;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    frame_done  = 1'b0;
    if (!resetN) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      wr_ready = (fifo_count != CW'(FIFO_DEPTH));
      push     = wr_valid & ~fifo_full;
      if (draw) begin
        mem_addr = rd_addr;
      end else if (!fifo_empty) begin
        mem_addr  = head[FW-1:DATA_W];
        mem_wdata = head[DATA_W-1:0];
        mem_we    = 1'b1;
        pop       = 1'b1;
      end
      pixel_valid = pv_q;
      pixel_data  = pv_q ? mem_rdata : '0;
      frame_done  = fd_q;
    end
  end

  // Scan address counter, vsync edge detect and the one-cycle scan-out
  // pipeline. The vsync restart wins over the increment.
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      rd_addr    <= '0;
      vsync_q    <= 1'b0;
      pv_q       <= 1'b0;
      fd_q       <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      vsync_q    <= v_sync_signal;
      pv_q       <= draw;
      fd_q       <= draw && (rd_addr == LAST_ADDR);
      hold_addr  <= mem_addr;
      hold_wdata <= mem_wdata;
      if (vsync_rise) begin
        rd_addr <= '0;
      end else if (draw) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
      end
    end
  end

`ifdef VRAM_STATS_EN
  // Counts cycles the writer was held off; restarts every frame.
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      stall_count <= '0;
    end else if (vsync_rise) begin
      stall_count <= '0;
    end else if (wr_valid && !wr_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Self-checking bench for vram_arbiter using a small geometry (16x4) so
// whole frames fit in a short run. A queue-based reference model predicts
// every output each cycle; table vectors and hand sequences add explicit
// expectations for the corner cases.
module tb_vram_arbiter;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LAST  = H * V - 1;

  logic          pixelClock = 1'b0;
  logic          resetN;
  logic          draw;
  logic          v_sync_signal;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pixel_data;
  logic          pixel_valid;
  logic          frame_done;
`ifdef VRAM_STATS_EN
  logic [15:0]   stall_count;
`endif

  always #5 pixelClock = ~pixelClock;

  vram_arbiter #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .pixelClock    (pixelClock),
    .resetN        (resetN),
    .draw          (draw),
    .v_sync_signal (v_sync_signal),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done)
`ifdef VRAM_STATS_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes as a queue, scan position as an int.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  int            m_rd = 0;
  bit            m_pv = 0;
  bit            m_fd = 0;
  bit            m_vs_prev = 0;
  int            m_stall = 0;
  logic [AW-1:0] m_hold_addr = '0;
  logic [DW-1:0] m_hold_data = '0;

  bit            e_ready, e_we, e_pv, e_fd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_pd;

  bit            obs_ready, obs_we, obs_pv, obs_fd;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata;

  typedef struct {
    bit            d;
    bit            wv;
    logic [AW-1:0] a;
    logic [DW-1:0] dat;
    bit            ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    bit            epv;
  } vec_t;

  vec_t tbl[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelPredict();
    if (!resetN) begin
      e_ready = 1; e_we = 0; e_addr = '0; e_wdata = '0;
      e_pv = 0; e_pd = '0; e_fd = 0;
    end else begin
      e_ready = (q.size() < DEPTH);
      e_we    = 0;
      e_addr  = m_hold_addr;
      e_wdata = m_hold_data;
      if (draw) begin
        e_addr = AW'(m_rd);
      end else if (q.size() > 0) begin
        e_we    = 1;
        e_addr  = q[0].a;
        e_wdata = q[0].d;
      end
      e_pv = m_pv;
      e_pd = m_pv ? mem_rdata : '0;
      e_fd = m_fd;
    end
  endfunction

  function automatic void modelUpdate();
    bit rise;
    wr_t w;
    if (!resetN) begin
      q.delete();
      m_rd = 0; m_pv = 0; m_fd = 0; m_vs_prev = 0; m_stall = 0;
      m_hold_addr = '0; m_hold_data = '0;
    end else begin
      rise = v_sync_signal && !m_vs_prev;
      if (rise) m_stall = 0;
      else if (wr_valid && !e_ready && m_stall < 65535) m_stall++;
      m_hold_addr = e_addr;
      m_hold_data = e_wdata;
      if (e_we) void'(q.pop_front());
      if (wr_valid && e_ready) begin
        w.a = wr_addr;
        w.d = wr_data;
        q.push_back(w);
      end
      m_fd = draw && (m_rd == LAST);
      m_pv = draw;
      if (rise) m_rd = 0;
      else if (draw) m_rd = (m_rd == LAST) ? 0 : m_rd + 1;
      m_vs_prev = v_sync_signal;
    end
  endfunction

  // One clock cycle: drive inputs, compare all outputs against the model
  // on the falling edge, then advance the model with the rising edge.
  task automatic applyStimulus(input bit rn, input bit d, input bit vs, input bit wv,
                               input logic [AW-1:0] a, input logic [DW-1:0] dat);
    resetN = rn; draw = d; v_sync_signal = vs; wr_valid = wv;
    wr_addr = a; wr_data = dat; mem_rdata = DW'($urandom);
    modelPredict();
    @(negedge pixelClock);
    obs_ready = wr_ready; obs_we = mem_we; obs_addr = mem_addr;
    obs_wdata = mem_wdata; obs_pv = pixel_valid; obs_fd = frame_done;
    checkOutput("wr_ready", 32'(wr_ready), 32'(e_ready));
    checkOutput("mem_we", 32'(mem_we), 32'(e_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    checkOutput("pixel_valid", 32'(pixel_valid), 32'(e_pv));
    checkOutput("pixel_data", 32'(pixel_data), 32'(e_pd));
    checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
`ifdef VRAM_STATS_EN
    if (rn) checkOutput("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    @(posedge pixelClock);
    modelUpdate();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, '0, '0);
  endtask

  initial begin
    int accepted;
    int fd_count;
    int run_left;
    bit d_cur;
    logic [AW-1:0] a;

    tbl[0]  = '{0, 1, 19'h00005, 8'hA5, 0, 19'h00000, 8'h00, 0};
    tbl[1]  = '{0, 0, 19'h00000, 8'h00, 1, 19'h00005, 8'hA5, 0};
    tbl[2]  = '{0, 0, 19'h00000, 8'h00, 0, 19'h00005, 8'hA5, 0};
    tbl[3]  = '{1, 1, 19'h00010, 8'h11, 0, 19'h00000, 8'hA5, 0};
    tbl[4]  = '{1, 1, 19'h00020, 8'h22, 0, 19'h00001, 8'hA5, 1};
    tbl[5]  = '{0, 0, 19'h00000, 8'h00, 1, 19'h00010, 8'h11, 1};
    tbl[6]  = '{0, 0, 19'h00000, 8'h00, 1, 19'h00020, 8'h22, 0};
    tbl[7]  = '{0, 0, 19'h00000, 8'h00, 0, 19'h00020, 8'h22, 0};
    tbl[8]  = '{0, 1, 19'h7FFFF, 8'h3C, 0, 19'h00020, 8'h22, 0};
    tbl[9]  = '{0, 0, 19'h00000, 8'h00, 1, 19'h7FFFF, 8'h3C, 0};
    tbl[10] = '{0, 1, 19'h00030, 8'h01, 0, 19'h7FFFF, 8'h3C, 0};
    tbl[11] = '{0, 1, 19'h00030, 8'h02, 1, 19'h00030, 8'h01, 0};
    tbl[12] = '{0, 0, 19'h00000, 8'h00, 1, 19'h00030, 8'h02, 0};
    tbl[13] = '{0, 0, 19'h00000, 8'h00, 0, 19'h00030, 8'h02, 0};

    resetN = 0; draw = 0; v_sync_signal = 0; wr_valid = 0;
    wr_addr = '0; wr_data = '0; mem_rdata = '0;
    @(posedge pixelClock);
    #1;

    // Reset held two cycles, then a quiet cycle after release.
    applyStimulus(0, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0);
    idle(1);
    checkOutput("post_reset_ready", 32'(obs_ready), 32'd1);
    checkOutput("post_reset_we", 32'(obs_we), 32'd0);
    checkOutput("post_reset_pv", 32'(obs_pv), 32'd0);

    // Table vectors: single write, writes during draw, out-of-range write,
    // simultaneous push and pop.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, tbl[i].d, 0, tbl[i].wv, tbl[i].a, tbl[i].dat);
      checkOutput($sformatf("vec%0d.we", i), 32'(obs_we), 32'(tbl[i].ewe));
      checkOutput($sformatf("vec%0d.addr", i), 32'(obs_addr), 32'(tbl[i].eaddr));
      checkOutput($sformatf("vec%0d.wdata", i), 32'(obs_wdata), 32'(tbl[i].ewd));
      checkOutput($sformatf("vec%0d.pv", i), 32'(obs_pv), 32'(tbl[i].epv));
    end

    // One scan line with three writes pushed during draw.
    applyStimulus(1, 0, 1, 0, '0, '0);
    idle(1);
    for (int i = 0; i < H; i++) begin
      applyStimulus(1, 1, 0, (i < 3), AW'(32'h100 + i), DW'(8'h40 + i));
      checkOutput("line.addr", 32'(obs_addr), 32'(i));
      checkOutput("line.we", 32'(obs_we), 32'd0);
      checkOutput("line.pv", 32'(obs_pv), 32'(i > 0));
    end
    for (int j = 0; j < 4; j++) begin
      idle(1);
      checkOutput("drain.we", 32'(obs_we), 32'(j < 3));
      if (j < 3) checkOutput("drain.addr", 32'(obs_addr), 32'h100 + 32'(j));
      checkOutput("drain.pv", 32'(obs_pv), 32'(j == 0));
    end

    // FIFO fill during draw: 16 accepted, the 17th waits for a blank pop.
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 1, AW'(32'h200 + accepted), DW'(accepted));
      if (obs_ready) accepted++;
      if (i >= 16) checkOutput("full.ready", 32'(obs_ready), 32'd0);
    end
    checkOutput("full.accepted", 32'(accepted), 32'd16);
    for (int b = 0; b < 18; b++) begin
      applyStimulus(1, 0, 0, (b <= 1), AW'(32'h200 + accepted), DW'(accepted));
      if (b <= 1 && obs_ready) accepted++;
      if (b == 0) checkOutput("full.ready_blank0", 32'(obs_ready), 32'd0);
      if (b == 1) checkOutput("full.ready_blank1", 32'(obs_ready), 32'd1);
      checkOutput("full.drain_we", 32'(obs_we), 32'(b <= 16));
      if (b <= 16) checkOutput("full.drain_addr", 32'(obs_addr), 32'h200 + 32'(b));
    end

    // A whole frame: frame_done exactly once, then the scan wraps to 0.
    applyStimulus(1, 0, 1, 0, '0, '0);
    idle(1);
    fd_count = 0;
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < H; p++) begin
        applyStimulus(1, 1, 0, 0, '0, '0);
        checkOutput("frame.addr", 32'(obs_addr), 32'(l * H + p));
        if (obs_fd) fd_count++;
      end
      for (int b = 0; b < 3; b++) begin
        idle(1);
        if (obs_fd) fd_count++;
        checkOutput("frame.fd", 32'(obs_fd), 32'(l == V - 1 && b == 0));
      end
    end
    checkOutput("frame.fd_count", 32'(fd_count), 32'd1);
    applyStimulus(1, 1, 0, 0, '0, '0);
    checkOutput("frame.wrap_addr", 32'(obs_addr), 32'd0);

    // Mid-frame vsync restarts the scan address.
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0, '0, '0);
    checkOutput("vsync.pre_addr", 32'(obs_addr), 32'd9);
    applyStimulus(1, 0, 1, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(1, 1, 0, 0, '0, '0);
    checkOutput("vsync.restart_addr", 32'(obs_addr), 32'd0);

    // Reset with five writes pending drops them all.
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1, AW'(32'h300 + i), DW'(i));
    applyStimulus(0, 0, 0, 0, '0, '0);
    checkOutput("rst.we_during", 32'(obs_we), 32'd0);
    applyStimulus(0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkOutput("rst.we_after", 32'(obs_we), 32'd0);
    end

    // Randomised traffic against the model.
    d_cur = 0;
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        d_cur = ~d_cur;
        run_left = $urandom_range(1, 24);
      end
      run_left--;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      applyStimulus(($urandom_range(0, 299) != 0), d_cur, ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 1) == 1), a, DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM between the display scan-out and a game-logic writer.
- Sits between msync (draw, h_sync_signal, v_sync_signal) and the VRAM macro.
- The display always owns the port while draw is high.
- Writer requests are buffered in a FIFO and drained during blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
ADDR_W, 19, VRAM address width (must hold H_ACTIVE*V_ACTIVE-1)
DATA_W, 8, pixel/word width
FIFO_DEPTH, 16, write FIFO entries (power of two, >=2)

Ports:
pixelClock  in  1  sole clock, rising edge
resetN  in  1  synchronous active-low reset
draw  in  1  from msync: visible pixel this cycle
v_sync_signal  in  1  from msync: rising edge restarts frame address
wr_valid  in  1  writer request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  FIFO can accept (push = wr_valid & wr_ready)
mem_addr  out  ADDR_W  VRAM address
mem_we  out  1  VRAM write enable
mem_wdata  out  DATA_W  VRAM write data
mem_rdata  in  DATA_W  VRAM read data, 1-cycle latency
pixel_data  out  DATA_W  pixel to DAC
pixel_valid  out  1  pixel_data is meaningful
frame_done  out  1  one-cycle pulse at end of last visible pixel

Behaviour:
- Reset: FIFO emptied (pending writes dropped), rd_addr=0, state=ST_VBLANK. Outputs during/after reset: wr_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, pixel_valid=0, pixel_data=0, frame_done=0. Reset mid-line or mid-drain aborts immediately.
- FSM states: ST_SCAN, ST_HBLANK, ST_VBLANK.
  - Any state with draw=1 -> ST_SCAN.
  - ST_SCAN with draw=0 -> ST_VBLANK if the previous fetch was address H_ACTIVE*V_ACTIVE-1; otherwise -> ST_HBLANK.
- Port ownership is decided combinationally from the current draw:
  - draw=1: mem_addr=rd_addr, mem_we=0, rd_addr increments.
  - draw=0 and FIFO non-empty: mem_addr/mem_wdata = FIFO head, mem_we=1, pop.
  - Otherwise mem_we=0 and mem_addr holds its last value.
- rd_addr is a linear counter. It wraps from H_ACTIVE*V_ACTIVE-1 to 0.
- A v_sync_signal rising edge (registered edge detect) forces rd_addr=0 next cycle. This takes precedence over increment.
- Scan-out latency is 1 cycle: pixel_valid(t+1)=draw(t), registered. pixel_data=mem_rdata when pixel_valid, else 0.
- frame_done pulses the cycle after the fetch of address H_ACTIVE*V_ACTIVE-1.
- FIFO:
  - Circular, count register of width clog2(FIFO_DEPTH)+1.
  - wr_ready = (count != FIFO_DEPTH), from the registered count. A pop in the same cycle does not un-block a push when full.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pushes are accepted in any state, including during draw.
- Writes to the same address drain in push order. Writes never reorder with respect to each other.
- A write whose wr_addr is greater than H_ACTIVE*V_ACTIVE-1 is still issued; the VRAM ignores it.

Optional Feature:
VRAM_STATS_EN
- Defined: adds output stall_count [15:0], a saturating count of cycles with wr_valid=1 and wr_ready=0. It clears to 0 on reset and on the v_sync_signal rising edge.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package vram_pkg: state encodings (ST_SCAN/ST_HBLANK/ST_VBLANK) and the FRAME_PIXELS = H_ACTIVE*V_ACTIVE constant.
- One sub-module: wr_fifo (parameterised DATA_W+ADDR_W wide, FIFO_DEPTH deep, push/pop/count/full/empty). The arbiter owns the FSM and counters.

Test Plan:
1. Hold resetN=0 for 2 cycles, then release -> wr_ready=1, mem_we=0, pixel_valid=0, frame_done=0, state ST_VBLANK.
2. draw=0, push addr 0x00005 data 0xA5 -> next cycle mem_we=1, mem_addr=0x00005, mem_wdata=0xA5; FIFO empty afterwards.
3. draw=1 for 640 cycles while pushing 3 writes:
   - mem_we=0 throughout and mem_addr steps 0..639.
   - The 3 writes appear in push order on the first 3 cycles after draw falls.
   - pixel_valid is high for cycles 1..640.
4. draw=1 and wr_valid=1 continuously -> 16 pushes accepted, then wr_ready=0. The 17th is held until the first blank cycle pops. With VRAM_STATS_EN, stall_count increments each blocked cycle.
5. Run 480 lines of 640 draw cycles -> frame_done pulses once after fetch of 307199, state ST_VBLANK, and the next draw fetches address 0.
6. Raise v_sync_signal mid-frame at rd_addr=1000 -> the next draw fetch is address 0. Assert resetN=0 with 5 FIFO entries pending -> no write issued after reset.
